spart_tx: RTL and testbench
===========================

SPART_TX -- requirements
Module: spart_tx

Interface
REQ-001 The parameter DIV SHALL default to 434 and SHALL set the number of clk cycles per serial bit (50 MHz / 115200 baud); legal values are 2..65535.
REQ-002 The parameter DEPTH SHALL default to 8 and SHALL set the number of TX FIFO entries; it SHALL be a power of 2 between 2 and 64.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port spart_tx_data SHALL be an input, 8 bits: the byte to transmit, sampled when spart_trmt=1.
REQ-006 Port spart_trmt SHALL be an input, 1 bit: a one-cycle push strobe from the memory-mapped write path.
REQ-007 Port spart_tx_full SHALL be an output, 1 bit: high when a push would be dropped; software polls it before writing.
REQ-008 Port tx_busy SHALL be an output, 1 bit: high while a frame is on the line or data is pending.
REQ-009 Port txd SHALL be an output, 1 bit: the registered serial line, idle high.

Function
REQ-010 A push SHALL occur on an edge where spart_trmt=1 and spart_tx_full=0; spart_tx_data is written at the tail and the count increments.
REQ-011 When spart_trmt=1 and spart_tx_full=1, the byte SHALL be dropped silently, with no state change, even if a pop occurs on the same edge.
REQ-012 spart_tx_full SHALL be registered and SHALL equal (count==DEPTH) after each edge.
REQ-013 The FSM SHALL have four states, IDLE, START, DATA and STOP, and SHALL reset to IDLE.
REQ-014 IDLE with count>0 SHALL, on the next edge, pop the head into an 8-bit shift register, drive txd=0 and enter START; IDLE with count=0 SHALL hold with txd=1.
REQ-015 A byte pushed into an empty FIFO while in IDLE SHALL cause txd to fall on the second edge after the push edge.
REQ-016 START SHALL last DIV cycles, then move to DATA with txd=bit0.
REQ-017 DATA SHALL shift LSB first, holding each bit for DIV cycles; after bit7 it SHALL move to STOP with txd=1.
REQ-018 STOP SHALL last DIV cycles; at its end it SHALL pop and go directly to START when count>0 (no idle gap), otherwise go to IDLE.
REQ-019 A frame SHALL last exactly 10*DIV cycles, and back-to-back frames SHALL be contiguous.
REQ-020 The bit timer SHALL be a 16-bit down counter reloaded with DIV-1 at every bit boundary; the bit index SHALL be a 3-bit counter.
REQ-021 A simultaneous push and pop with count<DEPTH SHALL leave count unchanged while the data order is preserved.
REQ-022 FIFO head and tail pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-023 tx_busy SHALL be high when the state is not IDLE or when count>0.

Reset
REQ-024 While rst=1 on an edge: txd=1, spart_tx_full=0, tx_busy=0, count=0, pointers=0, state=IDLE, timers=0.
REQ-025 A reset mid-frame SHALL abort the frame, with txd=1 from the next edge, and all buffered bytes SHALL be discarded.
REQ-026 A push asserted in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-027 With SPART_TX_FIFO_EN defined, the DEPTH-entry FIFO described above SHALL be built.
REQ-028 Without SPART_TX_FIFO_EN, the FIFO SHALL be replaced by one holding register (effective DEPTH=1), so that spart_tx_full=1 while the holding register is occupied; DEPTH is then ignored and all other behaviour is unchanged.

Verification (DIV=4, DEPTH=8, macro defined unless stated)
REQ-029 Push 0xA5 at idle: txd SHALL be 1 until the 2nd edge after the push, then produce the sequence 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles, and tx_busy SHALL fall 40 cycles after the falling start bit.
REQ-030 Push 0x01, 0x02 and 0x03 on consecutive cycles: there SHALL be three contiguous frames lasting 120 cycles total, with no idle cycle between stop and start.
REQ-031 Push 9 bytes on consecutive cycles while the first frame is active: spart_tx_full SHALL rise after the 8th accepted byte, the 9th byte SHALL be dropped, and full SHALL fall on the edge after the next pop.
REQ-032 Assert rst for 1 cycle during DATA bit3 with 4 bytes queued: txd SHALL be 1 on the next edge, tx_busy=0, spart_tx_full=0, and no further frames SHALL be sent.
REQ-033 Fill to count=8, then push on the same edge that STOP ends and pops: the push SHALL be dropped and count SHALL equal 7 afterwards.
REQ-034 With the macro undefined, push 0x55 twice on consecutive cycles: the second push SHALL be dropped because full=1, and exactly one frame SHALL be sent.

Source files
------------

// File: rtl/spart_tx.sv
// -----------------------------------------------------------------------------
// spart_tx : transmit half of a simple SPART (serial port) block.
//
// Bytes written by the memory-mapped write path are buffered and sent as
// 8N1 frames (start bit, 8 data bits LSB first, stop bit).  Each bit lasts
// DIV clk cycles.  Frames waiting in the buffer are sent back to back with
// no idle gap between a stop bit and the next start bit.
//
// Build option:
//   SPART_TX_FIFO_EN defined   -> DEPTH-entry circular FIFO buffer
//   SPART_TX_FIFO_EN undefined -> single holding register (DEPTH ignored)
//
// Parameters:
//   DIV    clk cycles per serial bit (2..65535), default 434
//   DEPTH  FIFO entries, power of 2 in 2..64, default 8
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   spart_tx_data  byte to transmit, sampled when spart_trmt=1
//   spart_trmt     one-cycle push strobe
//   spart_tx_full  registered: buffer full, a push now would be dropped
//   tx_busy        registered: frame on the line or bytes pending
//   txd            registered serial output, idle high
// -----------------------------------------------------------------------------
module spart_tx #(
    parameter int DIV   = 434,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spart_tx_data,
    input  logic       spart_trmt,
    output logic       spart_tx_full,
    output logic       tx_busy,
    output logic       txd
);

`ifdef SPART_TX_FIFO_EN
    localparam int DEPTH_EFF = DEPTH;
    localparam int AW        = $clog2(DEPTH);
`else
    // Single holding register; DEPTH is accepted but has no effect here.
    localparam int DEPTH_EFF = (DEPTH >= 1) ? 1 : 1;
`endif

    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [6:0]  DEPTH_C = 7'(DEPTH_EFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] timer_r, timer_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shreg_r, shreg_s;
    logic        txd_r, txd_s;
    logic [6:0]  count_r, count_s;
    logic        full_r, full_s;
    logic        busy_r, busy_s;
    logic        push_s;
    logic        pop_s;
    logic [7:0]  head_data_s;

    // A push is taken only when the buffer is not full; a dropped push has no
    // effect even if a pop happens on the same edge.
    assign push_s = spart_trmt & ~full_r;

    assign spart_tx_full = full_r;
    assign tx_busy       = busy_r;
    assign txd           = txd_r;

`ifdef SPART_TX_FIFO_EN
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;

    assign head_data_s = mem_r[head_r];

    // FIFO storage write port (data array is not reset; count qualifies it)
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[tail_r] <= spart_tx_data;
        end
    end

    // FIFO pointers, wrapping modulo DEPTH through natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= {AW{1'b0}};
            tail_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + AW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1);
            end
        end
    end
`else
    logic [7:0] hold_r;

    assign head_data_s = hold_r;

    // Holding register: loaded on an accepted push (only possible when empty)
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= 8'h00;
        end else if (push_s) begin
            hold_r <= spart_tx_data;
        end
    end
`endif

    // Next-state, bit timing and serial output decode for the frame FSM
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shreg_s   = shreg_r;
        txd_s     = txd_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != 7'd0) begin
                    pop_s   = 1'b1;
                    shreg_s = head_data_s;
                    txd_s   = 1'b0;
                    timer_s = DIV_M1;
                    state_s = START;
                end else begin
                    txd_s   = 1'b1;
                end
            end
            START: begin
                if (timer_r == 16'd0) begin
                    state_s   = DATA;
                    txd_s     = shreg_r[0];
                    bit_idx_s = 3'd0;
                    timer_s   = DIV_M1;
                end else begin
                    timer_s   = timer_r - 16'd1;
                end
            end
            DATA: begin
                if (timer_r == 16'd0) begin
                    timer_s = DIV_M1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                        txd_s   = 1'b1;
                    end else begin
                        // Present the next bit before shifting it down.
                        shreg_s   = {1'b0, shreg_r[7:1]};
                        txd_s     = shreg_r[1];
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            STOP: begin
                if (timer_r == 16'd0) begin
                    if (count_r != 7'd0) begin
                        // Chain straight into the next start bit.
                        pop_s   = 1'b1;
                        shreg_s = head_data_s;
                        txd_s   = 1'b0;
                        timer_s = DIV_M1;
                        state_s = START;
                    end else begin
                        txd_s   = 1'b1;
                        timer_s = 16'd0;
                        state_s = IDLE;
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            default: begin
                state_s   = IDLE;
                txd_s     = 1'b1;
                timer_s   = 16'd0;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // Occupancy update and registered status flags
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + 7'd1;
        end else if (pop_s && !push_s) begin
            count_s = count_r - 7'd1;
        end else begin
            count_s = count_r;
        end
        full_s = (count_s == DEPTH_C);
        busy_s = (state_s != IDLE) || (count_s != 7'd0);
    end

    // State, timer, shifter, occupancy and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            timer_r   <= 16'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            txd_r     <= 1'b1;
            count_r   <= 7'd0;
            full_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
            txd_r     <= txd_s;
            count_r   <= count_s;
            full_r    <= full_s;
            busy_r    <= busy_s;
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// -----------------------------------------------------------------------------
// tb_spart_tx : self-checking bench for spart_tx with DIV=4, DEPTH=8.
// Expectations adapt to whether SPART_TX_FIFO_EN is defined (FIFO vs single
// holding register).
// -----------------------------------------------------------------------------
module tb_spart_tx;

    localparam int DIV = 4;
`ifdef SPART_TX_FIFO_EN
    localparam logic FIFO_EN = 1'b1;
`else
    localparam logic FIFO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       trmt;
    logic       full;
    logic       busy;
    logic       txd;

    int checks = 0;
    int errors = 0;

    // Expected contiguous frame stream, frame 0 starting at sample k=0.
    logic [7:0] exp_bytes [16];
    int         exp_n;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;   // frame[9] is the first bit on the line
    } vec_t;

    vec_t vecs [6];

    spart_tx #(.DIV(DIV), .DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .spart_tx_data (data),
        .spart_trmt    (trmt),
        .spart_tx_full (full),
        .tx_busy       (busy),
        .txd           (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_txd(input int k);
        int f;
        int b;
        if (k >= exp_n * 40) return 1'b1;
        f = k / 40;
        b = (k % 40) / 4;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return exp_bytes[f][b-1];
    endfunction

    initial begin
        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h01, 10'b0100000001};
        vecs[4] = '{8'h80, 10'b0000000011};
        vecs[5] = '{8'h3C, 10'b0001111001};

        // Reset with a push held at the same time: the push must be ignored.
        rst  = 1'b1;
        trmt = 1'b1;
        data = 8'hFF;
        repeat (3) step();
        check("rst_txd",  txd,  1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        rst  = 1'b0;
        trmt = 1'b0;
        step();
        check("post_rst_txd",  txd,  1'b1);
        check("post_rst_busy", busy, 1'b0);
        step();
        check("post_rst_txd2", txd, 1'b1);

        // Single frames from idle, one per table entry.
        for (int v = 0; v < 6; v++) begin
            data = vecs[v].din;
            trmt = 1'b1;
            step();
            trmt = 1'b0;
            check("pre_start_txd",  txd,  1'b1);
            check("pre_start_busy", busy, 1'b1);
            check("pre_start_full", full, ~FIFO_EN);
            step();
            check("start_full", full, 1'b0);
            for (int k = 0; k < 40; k++) begin
                check("frame_txd",  txd,  vecs[v].frame[9 - k/4]);
                check("frame_busy", busy, 1'b1);
                step();
            end
            check("end_busy", busy, 1'b0);
            check("end_txd",  txd,  1'b1);
            repeat (3) step();
        end

        // Polled second push: two contiguous frames, 80 cycles total.
        exp_bytes[0] = 8'h01;
        exp_bytes[1] = 8'h02;
        exp_n        = 2;
        data = 8'h01;
        trmt = 1'b1;
        step();
        trmt = 1'b0;
        step();
        for (int k = 0; k < 85; k++) begin
            check("b2b_txd",  txd,  exp_txd(k));
            check("b2b_busy", busy, (k < 80));
            if (k == 1) check("b2b_full", full, ~FIFO_EN);
            trmt = (k == 0);
            data = 8'h02;
            step();
        end
        trmt = 1'b0;

        // Two pushes on consecutive cycles: holding register drops the second.
        exp_bytes[0] = 8'h55;
        exp_bytes[1] = 8'h55;
        exp_n        = FIFO_EN ? 2 : 1;
        data = 8'h55;
        trmt = 1'b1;
        step();
        step();
        trmt = 1'b0;
        for (int k = 0; k < 85; k++) begin
            check("dbl_txd",  txd,  exp_txd(k));
            check("dbl_busy", busy, (k < exp_n * 40));
            step();
        end

        // Reset during DATA bit3 with bytes queued: abort and discard.
        exp_bytes[0] = 8'hA5;
        exp_n        = 1;
        data = 8'hA5;
        trmt = 1'b1;
        step();
        trmt = 1'b0;
        step();
        for (int k = 0; k < 18; k++) begin
            check("abort_txd", txd, exp_txd(k));
            trmt = (k < 4);
            data = 8'h11 + 8'(k);
            step();
        end
        trmt = 1'b0;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
        check("abort_rst_txd",  txd,  1'b1);
        check("abort_rst_busy", busy, 1'b0);
        check("abort_rst_full", full, 1'b0);
        for (int k = 0; k < 100; k++) begin
            step();
            check("abort_quiet_txd",  txd,  1'b1);
            check("abort_quiet_busy", busy, 1'b0);
        end

`ifdef SPART_TX_FIFO_EN
        // Fill to eight while frame 0 runs, drop the ninth, then push on the
        // STOP-end pop edge (dropped) and once more just after (accepted).
        exp_bytes[0] = 8'h10;
        for (int i = 1; i <= 8; i++) exp_bytes[i] = 8'h20 + 8'(i);
        exp_bytes[9] = 8'h3A;
        exp_n        = 10;
        data = 8'h10;
        trmt = 1'b1;
        step();
        trmt = 1'b0;
        step();
        for (int k = 0; k < 406; k++) begin
            check("fill_txd",  txd,  exp_txd(k));
            check("fill_busy", busy, (k < 400));
            if (k <= 41) check("fill_full", full, (k >= 8 && k <= 39) || (k == 41));
            trmt = (k <= 8) || (k == 39) || (k == 40);
            if (k <= 7)       data = 8'h21 + 8'(k);
            else if (k == 8)  data = 8'hEE;
            else if (k == 39) data = 8'hEF;
            else              data = 8'h3A;
            step();
        end
        trmt = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
